// File: rtl/symfir_pkg.sv
// Shared types and helpers for the serial symmetric FIR scheduler.
package symfir_pkg;

  typedef enum logic [2:0] {IDLE, WRITE, MAC, DRAIN, OUT} state_e;

  // (a - b) mod n for a, b < n: one extra bit catches the borrow, a single +n repairs it.
  function automatic logic [15:0] mod_sub(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] n);
    logic [16:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[16]) d = d + {1'b0, n};
    return d[15:0];
  endfunction

endpackage

// File: rtl/symfir_addr_gen.sv
// Pair-address generator: k counter plus registered tap/coef addresses for the MAC phase.
module symfir_addr_gen #(
  parameter int NTAPS = 16,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step,
  input  logic [AW-1:0] wr_ptr,
  output logic          k_last,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [AW-1:0] coef_addr,
  output logic          mid_tap
);
  import symfir_pkg::*;

  localparam int H   = (NTAPS + 1) / 2;
  localparam bit ODD = (NTAPS % 2) == 1;

  logic [AW-1:0] k_q, k_d, a_q, a_d, b_q, b_d, k_nxt;
  logic          mid_q, mid_d;

  // Addresses are loaded one cycle ahead so they line up with the registered mac_en.
  always_comb begin
    k_nxt = start ? '0 : k_q + 1'b1;
    k_d   = k_q;
    a_d   = a_q;
    b_d   = b_q;
    mid_d = 1'b0;
    if (start || step) begin
      k_d   = k_nxt;
      a_d   = AW'(mod_sub(16'(wr_ptr), 16'(k_nxt), 16'(NTAPS)));
      b_d   = AW'(mod_sub(16'(wr_ptr), 16'(AW'(NTAPS - 1) - k_nxt), 16'(NTAPS)));
      mid_d = ODD && (k_nxt == AW'(H - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      mid_q <= 1'b0;
    end else begin
      k_q   <= k_d;
      a_q   <= a_d;
      b_q   <= b_d;
      mid_q <= mid_d;
    end
  end

  assign k_last    = (k_q == AW'(H - 1));
  assign rd_addr_a = a_q;
  assign rd_addr_b = b_q;
  assign coef_addr = k_q;
  assign mid_tap   = mid_q;

endmodule

// File: rtl/symfir_mac_sched.sv
// Sample/MAC sequencer for the serial symmetric FIR datapath.
// Optional SYMFIR_PRIME_EN: suppress outputs until the delay line holds NTAPS real samples.
module symfir_mac_sched #(
  parameter  int NTAPS   = 16,
  parameter  int MAC_LAT = 2,
  localparam int AW      = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [AW-1:0] coef_addr,
  output logic          mid_tap,
  output logic          mac_clear,
  output logic          mac_en,
  output logic          out_valid,
  input  logic          out_ready
);
  import symfir_pkg::*;

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_inc;
  logic [DW-1:0] drain_q, drain_d;
  logic          in_ready_q, in_ready_d, wr_en_q, wr_en_d;
  logic          mac_en_q, mac_en_d, mac_clear_q, mac_clear_d;
  logic          out_valid_q, out_valid_d;
  logic          accept, start, step, done, k_last, primed;

  assign accept     = (state_q == IDLE) && in_valid && in_ready_q;
  assign wr_ptr_inc = (wr_ptr_q == AW'(NTAPS - 1)) ? '0 : wr_ptr_q + 1'b1;

`ifdef SYMFIR_PRIME_EN
  localparam int PW = $clog2(NTAPS + 1);
  logic [PW-1:0] prime_cnt_q, prime_cnt_d;

  always_comb begin
    prime_cnt_d = prime_cnt_q;
    if (accept && (prime_cnt_q != PW'(NTAPS))) prime_cnt_d = prime_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prime_cnt_q <= '0;
    else        prime_cnt_q <= prime_cnt_d;
  end

  assign primed = (prime_cnt_q == PW'(NTAPS));
`else
  assign primed = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    drain_d     = drain_q;
    in_ready_d  = in_ready_q;
    wr_en_d     = 1'b0;
    mac_en_d    = 1'b0;
    mac_clear_d = 1'b0;
    out_valid_d = out_valid_q;
    start       = 1'b0;
    step        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          state_d    = WRITE;
          in_ready_d = 1'b0;
          wr_en_d    = 1'b1;
        end
      end
      WRITE: begin
        state_d     = MAC;
        start       = 1'b1;
        mac_en_d    = 1'b1;
        mac_clear_d = 1'b1;
      end
      MAC: begin
        if (!k_last) begin
          step     = 1'b1;
          mac_en_d = 1'b1;
        end else if (MAC_LAT == 0) begin
          done = 1'b1;
        end else begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (drain_q == DW'(MAC_LAT - 1)) done = 1'b1;
        else                             drain_d = drain_q + 1'b1;
      end
      OUT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          wr_ptr_d    = wr_ptr_inc;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // An unprimed result is dropped: straight back to IDLE, but the sample still occupies its slot.
    if (done) begin
      if (primed) begin
        state_d     = OUT;
        out_valid_d = 1'b1;
      end else begin
        state_d    = IDLE;
        wr_ptr_d   = wr_ptr_inc;
        in_ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      drain_q     <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_clear_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      drain_q     <= drain_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      mac_en_q    <= mac_en_d;
      mac_clear_q <= mac_clear_d;
      out_valid_q <= out_valid_d;
    end
  end

  symfir_addr_gen #(.NTAPS(NTAPS), .AW(AW)) u_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .step      (step),
    .wr_ptr    (wr_ptr_q),
    .k_last    (k_last),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .coef_addr (coef_addr),
    .mid_tap   (mid_tap)
  );

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_ptr_q;
  assign mac_en    = mac_en_q;
  assign mac_clear = mac_clear_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_symfir_mac_sched.sv
// Directed bench: NTAPS=16/MAC_LAT=2 instance plus an odd NTAPS=5/MAC_LAT=0 instance.
module tb_symfir_mac_sched;

`ifdef SYMFIR_PRIME_EN
  localparam bit PRIME = 1'b1;
`else
  localparam bit PRIME = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, wr_en, mid_tap, mac_clear, mac_en, out_valid;
  logic [3:0] wr_addr, rd_a, rd_b, coef;

  logic       in_valid5 = 1'b0, out_ready5 = 1'b1;
  logic       in_ready5, wr_en5, mid5, mac_clear5, mac_en5, out_valid5;
  logic [2:0] wr_addr5, rd_a5, rd_b5, coef5;

  int checks = 0;
  int failures = 0;
  int ov5_cnt = 0;

  symfir_mac_sched #(.NTAPS(16), .MAC_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr_a(rd_a), .rd_addr_b(rd_b),
    .coef_addr(coef), .mid_tap(mid_tap), .mac_clear(mac_clear), .mac_en(mac_en),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  symfir_mac_sched #(.NTAPS(5), .MAC_LAT(0)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .wr_en(wr_en5), .wr_addr(wr_addr5), .rd_addr_a(rd_a5), .rd_addr_b(rd_b5),
    .coef_addr(coef5), .mid_tap(mid5), .mac_clear(mac_clear5), .mac_en(mac_en5),
    .out_valid(out_valid5), .out_ready(out_ready5)
  );

  always @(negedge clk) if (rst_n && out_valid5) ov5_cnt <= ov5_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy16();
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("wait_in_ready", in_ready, 1);
  endtask

  // One full transaction on the 16-tap instance with out_ready held high.
  task automatic send16(input int exp_addr, input bit exp_out);
    wait_rdy16();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("s6_wr_en", wr_en, 1);
    chk("s6_wr_addr", wr_addr, exp_addr);
    repeat (11) tick();
    chk("s6_out_valid", out_valid, exp_out);
    tick();
    chk("s6_out_drop", out_valid, 0);
    chk("s6_back_idle", in_ready, 1);
  endtask

  initial begin
    int seen, base, p;
    // reset state
    tick(); tick();
    chk("rst_outputs", {in_ready, wr_en, mac_en, mac_clear, mid_tap, out_valid}, 0);
    chk("rst_addrs", {wr_addr, rd_a, rd_b, coef}, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1);

    // first sample: timing and pair addresses with wr_ptr=0
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_wr_en", wr_en, 1);
    chk("t1_wr_addr", wr_addr, 0);
    chk("t1_in_ready_low", in_ready, 0);
    chk("t1_no_mac_yet", mac_en, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2_mac_en", mac_en, 1);
      chk("t2_mac_clear", mac_clear, (k == 0));
      chk("t2_coef", coef, k);
      chk("t2_rd_a", rd_a, (16 - k) % 16);
      chk("t2_rd_b", rd_b, k + 1);
      chk("t2_mid_tap", mid_tap, 0);
    end
    tick();
    chk("t1_drain_mac_off", {mac_en, mac_clear, wr_en}, 0);
    chk("t1_drain_hold_a", rd_a, 9);
    chk("t1_drain_hold_b", rd_b, 8);
    chk("t1_drain_no_out", out_valid, 0);
    tick();
    chk("t1_t11_no_out", out_valid, 0);
    tick();
    chk("t1_t12_out", out_valid, !PRIME);

`ifndef SYMFIR_PRIME_EN
    // back-pressure: output held, input refused
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      tick();
      chk("t4_out_held", out_valid, 1);
      chk("t4_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t4_out_done", out_valid, 0);
    chk("t4_idle", in_ready, 1);
    chk("t4_wr_ptr_inc", wr_addr, 1);
`else
    out_ready = 1'b1;
    tick();
    chk("t4_idle", in_ready, 1);
    chk("t4_wr_ptr_inc", wr_addr, 1);
`endif

    // second sample: wr_ptr=1, out_ready already high gives a one-cycle pulse
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t2b_wr_addr", wr_addr, 1);
    tick();
    chk("t2b_k0_a", rd_a, 1);
    chk("t2b_k0_b", rd_b, 2);
    repeat (10) tick();
    chk("t2b_out_pulse", out_valid, !PRIME);
    tick();
    chk("t2b_out_gone", out_valid, 0);
    chk("t2b_in_ready", in_ready, 1);
    chk("t2b_wr_ptr", wr_addr, 2);

    // async reset mid-MAC at k=4
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("t5_at_k4", coef, 4);
    chk("t5_mac_active", mac_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_strobes", {in_ready, wr_en, mac_en, mac_clear, mid_tap, out_valid}, 0);
    chk("t5_async_addrs", {wr_addr, rd_a, rd_b, coef}, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("t5_rel_in_ready", in_ready, 1);
    chk("t5_rel_wr_ptr", wr_addr, 0);
    seen = 0;
    repeat (15) begin tick(); if (out_valid !== 1'b0) seen++; end
    chk("t5_no_out_valid", seen, 0);

    // priming behaviour (every sample produces output when priming is off)
    for (int s = 0; s < 18; s++) send16(s % 16, PRIME ? (s >= 15) : 1'b1);

    // odd length, MAC_LAT=0, wrap of wr_ptr over 17 samples
    base = ov5_cnt;
    for (int s = 0; s < 17; s++) begin
      int n = 0;
      while (!in_ready5 && n < 50) begin tick(); n++; end
      chk("t3_wait_ready", in_ready5, 1);
      p = s % 5;
      in_valid5 = 1'b1;
      tick();
      in_valid5 = 1'b0;
      chk("t3_wr_en", wr_en5, 1);
      chk("t3_wr_addr", wr_addr5, p);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("t3_mac_en", mac_en5, 1);
        chk("t3_rd_a", rd_a5, (p - k + 5) % 5);
        chk("t3_rd_b", rd_b5, (p + k + 1) % 5);
        chk("t3_mid_tap", mid5, (k == 2));
        if (s == 0 && k == 2) chk("t3_centre_a_eq_b", {rd_a5, rd_b5}, {3'd3, 3'd3});
      end
      tick();
      chk("t3_out_valid", out_valid5, PRIME ? (s >= 4) : 1'b1);
      chk("t3_mid_cleared", {mid5, mac_en5}, 0);
      tick();
      chk("t3_back_idle", in_ready5, 1);
    end
    chk("t3_wrap_ptr", wr_addr5, 2);
    chk("t3_out_count", ov5_cnt - base, PRIME ? 13 : 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
